sort_three_floats_seq: RTL and testbench
========================================

// Module: sort_three_floats_seq
// PURPOSE
//  Upstream feeder/sorter for 3-element FP sorting. Accepts a serial stream of FP
//  values (valid/ready), groups them into triples, and sorts each triple over
//  several cycles with ONE shared f_less_or_equal comparator (3 compare-swap steps).
//  Emits the sorted triple plus an error flag over a valid/ready handshake.
//  It is the area-lean, multi-cycle alternative to the 3-comparator combinational sorter.
// PARAMETERS
//  FLEN  global (config-shared.vh, normally 64)  FP width; not a local parameter.
//  No local parameters.
// PORTS
//  clk         in   1          clock, all state on rising edge
//  rst_n       in   1          asynchronous, active-low reset
//  in_valid    in   1          in_data valid
//  in_ready    out  1          block can accept in_data this cycle
//  in_data     in   FLEN       next unsorted FP element
//  out_valid   out  1          out_sorted/out_err valid
//  out_ready   in   1          consumer accepts output this cycle
//  out_sorted  out  [0:2][FLEN] ascending: [0] <= [1] <= [2]
//  out_err     out  1          some comparison of this triple flagged err (NaN etc.)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=COLLECT, count=0, in_ready=1, out_valid=0,
//    out_err=0, out_sorted=0. Reset mid-operation drops any partial/in-flight triple.
//  - Registers: buf[0:2] FLEN each, count 2b, err_acc 1b, state.
//  - COLLECT: in_ready=1; on in_valid&&in_ready: buf[count]<=in_data, count++.
//    The 3rd handshake (count==2) -> count<=0, err_acc<=0, state<=CMP01A.
//  - CMP01A: compare buf0,buf1. CMP12: compare buf1,buf2. CMP01B: compare buf0,buf1.
//    Each step, one cycle: comparator a=lower index, b=higher index.
//    If res==0 && err==0: swap the pair. If err==1: no swap. err_acc |= err.
//    CMP01A->CMP12->CMP01B->OUT unconditionally; in_ready=0 in all CMP states.
//  - OUT: out_valid=1, out_sorted=buf, out_err=err_acc, in_ready=0; outputs stable
//    while out_valid && !out_ready. On out_valid&&out_ready -> COLLECT.
//    No same-cycle bypass: in_ready rises the cycle after the output handshake.
//  - Latency: out_valid high 3 rising edges after the edge accepting the 3rd element.
//    Throughput: one triple per 3+4 cycles min (3 accept + 3 sort + 1 out).
//  - Equal values: no swap (stable order). +0/-0 compare equal per f_less_or_equal.
//  - in_valid while in_ready=0: ignored, data not consumed.
//  - With out_err=1, out_sorted is the result of the no-swap rule; not guaranteed sorted.
//  - count never exceeds 2; no wrap hazard. Only the listed states are reachable;
//    the default branch returns to COLLECT.
// STRUCTURE
//  - Package sort_seq_pkg: typedef enum logic [2:0] {COLLECT, CMP01A, CMP12, CMP01B, OUT}
//    sort_seq_state_t; localparam NUM_ELEMS = 3.
//  - One sub-module: the existing f_less_or_equal, single instance, inputs muxed by state.
//  - Everything else (FSM, buffer, swap logic) is inline.
// TESTING (FP64 hex: 1.0=3FF0..0, 2.0=4000..0, 3.0=4008..0, -1.0=BFF0..0, NaN=7FF8..0)
//  - Send 3.0,1.0,2.0 with out_ready=1 -> out_sorted={1.0,2.0,3.0}, out_err=0,
//    out_valid 3 edges after the 3rd accept.
//  - Send -1.0,3.0,1.0 then 2.0,2.0,1.0 back-to-back with in_valid always high ->
//    {-1.0,1.0,3.0} then {1.0,2.0,2.0}; in_ready low from 3rd accept to output handshake.
//  - Send 1.0,NaN,2.0 -> out_valid with out_err=1; no X on out_sorted.
//  - Hold out_ready=0 for 5 cycles in OUT -> out_valid/out_sorted stable, in_ready=0.
//  - Toggle in_valid randomly, 0-3 idle cycles between elements -> correct grouping.
//  - Assert rst_n=0 after 2 accepted elements, then release and send 2.0,3.0,1.0 ->
//    only {1.0,2.0,3.0} emitted; outputs are 0/low during reset.
//  - Scoreboard: random FP64 triples (no NaN) vs reference sort, plus sorted check.

Source files
------------

// File: rtl/sort_three_floats_seq_pkg.sv
// Shared types and constants for the sequential three-element FP sorter.
package sort_seq_pkg;

    // FP width shared with the rest of the FP datapath (normally FP64).
    localparam int FLEN      = 64;
    localparam int NUM_ELEMS = 3;

    typedef enum logic [2:0] {
        COLLECT,
        CMP01A,
        CMP12,
        CMP01B,
        OUT
    } sort_seq_state_t;

endpackage

// File: rtl/sort_three_floats_seq_f_less_or_equal.sv
// IEEE-754 a <= b comparator; err flags a NaN operand, and res is 0 whenever err is set.
module f_less_or_equal
    import sort_seq_pkg::*;
(
    input  logic [FLEN-1:0] a_i,
    input  logic [FLEN-1:0] b_i,
    output logic            res_o,
    output logic            err_o
);

    localparam int EXP_W = (FLEN == 32) ? 8 : 11;
    localparam int MAN_W = FLEN - 1 - EXP_W;

    logic            a_sign, b_sign, a_nan, b_nan, both_zero;
    logic [FLEN-2:0] a_mag, b_mag;

    assign a_sign    = a_i[FLEN-1];
    assign b_sign    = b_i[FLEN-1];
    assign a_mag     = a_i[FLEN-2:0];
    assign b_mag     = b_i[FLEN-2:0];
    assign a_nan     = (&a_i[FLEN-2 -: EXP_W]) && (|a_i[MAN_W-1:0]);
    assign b_nan     = (&b_i[FLEN-2 -: EXP_W]) && (|b_i[MAN_W-1:0]);
    // +0 and -0 must compare equal regardless of sign.
    assign both_zero = (a_mag == '0) && (b_mag == '0);

    always_comb begin
        err_o = a_nan | b_nan;
        res_o = 1'b0;
        if (!err_o) begin
            if (both_zero)
                res_o = 1'b1;
            else if (a_sign != b_sign)
                res_o = a_sign;
            else if (!a_sign)
                res_o = (a_mag <= b_mag);
            else
                res_o = (a_mag >= b_mag);
        end
    end

endmodule

// File: rtl/sort_three_floats_seq.sv
// Collects FP values into triples and sorts each with one shared comparator in three
// compare-swap steps, then presents the sorted triple over a valid/ready handshake.
module sort_three_floats_seq
    import sort_seq_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [FLEN-1:0]                      in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [0:NUM_ELEMS-1][FLEN-1:0]       out_sorted,
    output logic                                 out_err
);

    sort_seq_state_t                    state_q, state_d;
    logic [0:NUM_ELEMS-1][FLEN-1:0]     buf_q, buf_d;
    logic [1:0]                         count_q, count_d;
    logic                               err_acc_q, err_acc_d;

    logic [1:0]      lo_idx, hi_idx;
    logic [FLEN-1:0] cmp_a, cmp_b;
    logic            cmp_res, cmp_err;

    // Only CMP12 looks at the upper pair; the other compare states use elements 0/1.
    assign lo_idx = (state_q == CMP12) ? 2'd1 : 2'd0;
    assign hi_idx = lo_idx + 2'd1;
    assign cmp_a  = buf_q[lo_idx];
    assign cmp_b  = buf_q[hi_idx];

    f_less_or_equal u_cmp (
        .a_i   (cmp_a),
        .b_i   (cmp_b),
        .res_o (cmp_res),
        .err_o (cmp_err)
    );

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        count_d    = count_q;
        err_acc_d  = err_acc_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_sorted = '0;
        out_err    = 1'b0;
        unique case (state_q)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    buf_d[count_q] = in_data;
                    if (count_q == 2'd2) begin
                        count_d   = 2'd0;
                        err_acc_d = 1'b0;
                        state_d   = CMP01A;
                    end else begin
                        count_d = count_q + 2'd1;
                    end
                end
            end
            CMP01A, CMP12, CMP01B: begin
                err_acc_d = err_acc_q | cmp_err;
                // A NaN-tainted pair is left in place rather than ordered arbitrarily.
                if (!cmp_res && !cmp_err) begin
                    buf_d[lo_idx] = cmp_b;
                    buf_d[hi_idx] = cmp_a;
                end
                case (state_q)
                    CMP01A:  state_d = CMP12;
                    CMP12:   state_d = CMP01B;
                    default: state_d = OUT;
                endcase
            end
            OUT: begin
                out_valid  = 1'b1;
                out_sorted = buf_q;
                out_err    = err_acc_q;
                if (out_ready)
                    state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= COLLECT;
            buf_q     <= '0;
            count_q   <= 2'd0;
            err_acc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            count_q   <= count_d;
            err_acc_q <= err_acc_d;
        end
    end

endmodule

// File: tb/tb_sort_three_floats_seq.sv
// Directed and scoreboard bench for the sequential three-element FP sorter.
module tb_sort_three_floats_seq;

    localparam logic [63:0] P1   = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] P2   = 64'h4000_0000_0000_0000;
    localparam logic [63:0] P3   = 64'h4008_0000_0000_0000;
    localparam logic [63:0] M1   = 64'hBFF0_0000_0000_0000;
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] PZ   = 64'h0000_0000_0000_0000;
    localparam logic [63:0] NZ   = 64'h8000_0000_0000_0000;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [63:0]           in_data = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [0:2][63:0]      out_sorted;
    logic                  out_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sort_three_floats_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sorted (out_sorted),
        .out_err    (out_err)
    );

    // All tasks run in the phase 1ns after a rising edge.
    task automatic send(input logic [63:0] d, input int idle);
        int n;
        if (idle > 0) begin
            in_valid = 1'b0;
            repeat (idle) begin @(posedge clk); #1; end
        end
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic get_out(output logic [0:2][63:0] s, output logic e, input int stall);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL get_out_wait: out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
        end
        s = out_sorted;
        e = out_err;
        repeat (stall) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_sorted !== s || out_err !== e || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_stable: valid=%b rdy=%b sorted=%h required %h", out_valid, in_ready, out_sorted, s);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sorted !== '0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b rdy=%b err=%b sorted=%h required 0/1/0/0", out_valid, in_ready, out_err, out_sorted);
        end
    endtask

    task automatic test_basic_latency();
        logic [0:2][63:0] exp_s;
        exp_s = {P1, P2, P3};
        out_ready = 1'b1;
        send(P3, 0);
        send(P1, 0);
        send(P2, 0);
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL latency_early k=%0d: valid=%b rdy=%b required 0/0", k, out_valid, in_ready);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early k=2: valid=%b required 0", out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_sorted !== exp_s || out_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_sort: valid=%b err=%b sorted=%h required 1/0/%h", out_valid, out_err, out_sorted, exp_s);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_handshake: valid=%b rdy=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [0:2][63:0] s0, s1;
        logic             e0, e1;
        fork
            begin
                send(M1, 0); send(P3, 0); send(P1, 0);
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_ready_low: in_ready=%b required 0", in_ready);
                end
                send(P2, 0); send(P2, 0); send(P1, 0);
                in_valid = 1'b0;
            end
            begin
                get_out(s0, e0, 0);
                get_out(s1, e1, 0);
            end
        join
        checks++;
        if (s0 !== {M1, P1, P3} || e0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: sorted=%h err=%b required %h/0", s0, e0, {M1, P1, P3});
        end
        checks++;
        if (s1 !== {P1, P2, P2} || e1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: sorted=%h err=%b required %h/0", s1, e1, {P1, P2, P2});
        end
    endtask

    task automatic test_nan();
        logic [0:2][63:0] s;
        logic             e;
        send(P1, 0); send(QNAN, 0); send(P2, 0);
        in_valid = 1'b0;
        get_out(s, e, 0);
        checks++;
        if (e !== 1'b1 || s !== {P1, QNAN, P2}) begin
            errors++;
            $display("FAIL nan_err: sorted=%h err=%b required %h/1", s, e, {P1, QNAN, P2});
        end
    endtask

    task automatic test_signed_zero();
        logic [0:2][63:0] s;
        logic             e;
        send(NZ, 0); send(PZ, 0); send(M1, 0);
        in_valid = 1'b0;
        get_out(s, e, 0);
        checks++;
        if (e !== 1'b0 || s !== {M1, NZ, PZ}) begin
            errors++;
            $display("FAIL signed_zero: sorted=%h err=%b required %h/0", s, e, {M1, NZ, PZ});
        end
    endtask

    task automatic test_stall();
        logic [0:2][63:0] s;
        logic             e;
        send(P3, 0); send(P2, 0); send(P1, 0);
        in_valid = 1'b0;
        get_out(s, e, 5);
        checks++;
        if (s !== {P1, P2, P3} || e !== 1'b0) begin
            errors++;
            $display("FAIL stall_result: sorted=%h err=%b required %h/0", s, e, {P1, P2, P3});
        end
    endtask

    task automatic test_random_idle();
        logic [0:2][63:0] s0, s1;
        logic             e0, e1;
        fork
            begin
                send(P2, $urandom_range(0, 3)); send(M1, $urandom_range(0, 3)); send(P3, $urandom_range(0, 3));
                send(P1, $urandom_range(0, 3)); send(P1, $urandom_range(0, 3)); send(M1, $urandom_range(0, 3));
                in_valid = 1'b0;
            end
            begin
                get_out(s0, e0, $urandom_range(0, 2));
                get_out(s1, e1, $urandom_range(0, 2));
            end
        join
        checks++;
        if (s0 !== {M1, P2, P3} || e0 !== 1'b0) begin
            errors++;
            $display("FAIL idle_first: sorted=%h err=%b required %h/0", s0, e0, {M1, P2, P3});
        end
        checks++;
        if (s1 !== {M1, P1, P1} || e1 !== 1'b0) begin
            errors++;
            $display("FAIL idle_second: sorted=%h err=%b required %h/0", s1, e1, {M1, P1, P1});
        end
    endtask

    task automatic test_reset_midway();
        logic [0:2][63:0] s;
        logic             e;
        send(P1, 0); send(M1, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sorted !== '0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b rdy=%b err=%b sorted=%h required 0/1/0/0", out_valid, in_ready, out_err, out_sorted);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(P2, 0); send(P3, 0); send(P1, 0);
        in_valid = 1'b0;
        get_out(s, e, 0);
        checks++;
        if (s !== {P1, P2, P3} || e !== 1'b0) begin
            errors++;
            $display("FAIL reset_resume: sorted=%h err=%b required %h/0", s, e, {P1, P2, P3});
        end
    endtask

    task automatic test_scoreboard();
        logic [63:0]      v [3];
        logic [63:0]      t;
        logic [0:2][63:0] s;
        logic             e;
        int               j;
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < 3; i++) begin
                v[i] = {$urandom, $urandom};
                if (v[i][62:52] == 11'h7FF) v[i][62:52] = 11'h7FE;
                if (n == 0 && i == 2) v[i] = v[0];
            end
            send(v[0], 0); send(v[1], 0); send(v[2], 0);
            in_valid = 1'b0;
            get_out(s, e, 0);
            for (int i = 1; i < 3; i++) begin
                j = i;
                while (j > 0 && $bitstoreal(v[j-1]) > $bitstoreal(v[j])) begin
                    t = v[j]; v[j] = v[j-1]; v[j-1] = t; j--;
                end
            end
            checks++;
            if (s !== {v[0], v[1], v[2]} || e !== 1'b0 ||
                $bitstoreal(s[0]) > $bitstoreal(s[1]) || $bitstoreal(s[1]) > $bitstoreal(s[2])) begin
                errors++;
                $display("FAIL scoreboard n=%0d: sorted=%h err=%b required %h/0", n, s, e, {v[0], v[1], v[2]});
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic_latency();
        test_back_to_back();
        test_nan();
        test_signed_zero();
        test_stall();
        test_random_idle();
        test_reset_midway();
        test_scoreboard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
